// File: rtl/ser_pkg.sv
// Shared widths, word shape and FSM encoding for the nibble serializer.
package ser_pkg;
   localparam int unsigned WORD_W = 48;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned BEATS  = WORD_W / NIB_W;
   localparam int unsigned CNT_W  = 4;

   typedef logic [2:1][4:1][1:3][0:1] ser_word_t;

   typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_e;
endpackage

// File: rtl/ser_beat_ctr.sv
// Beat counter: clears to zero on a word load, increments per accepted beat,
// saturates at BEATS-1 and flags the last beat.
module ser_beat_ctr
   import ser_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             is_last_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign is_last_o = (cnt_q == CNT_W'(BEATS - 1));
   assign cnt_o     = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !is_last_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/iem_nibble_serializer.sv
// Serializes a 48-bit word into 12 MSB-first nibble beats over valid/ready.
// Optional SER_PARITY_EN adds an even-parity bit (out_par) per beat.
module iem_nibble_serializer
   import ser_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  ser_word_t         in_word,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [NIB_W-1:0]  out_nib,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [CNT_W-1:0]  out_beat_idx,
   output logic              busy
`ifdef SER_PARITY_EN
   ,
   output logic              out_par
`endif
);

   ser_state_e        state_q;
   ser_state_e        state_d;
   logic [WORD_W-1:0] shreg_q;
   logic [WORD_W-1:0] shreg_d;
   logic [CNT_W-1:0]  cnt;
   logic              is_last;
   logic              load;
   logic              inc;
   logic              shifting;

   ser_beat_ctr u_beat_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (load),
      .inc_i     (inc),
      .cnt_o     (cnt),
      .is_last_o (is_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SER_IDLE;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SER_IDLE:  if (in_valid) state_d = SER_SHIFT;
         SER_SHIFT: if (out_ready && is_last && !in_valid) state_d = SER_IDLE;
         default:   state_d = SER_IDLE;
      endcase
   end

   // Handshake decode; a last-beat handshake may reload without a bubble.
   always_comb begin
      in_ready = 1'b0;
      load     = 1'b0;
      inc      = 1'b0;
      case (state_q)
         SER_IDLE: begin
            in_ready = 1'b1;
            load     = in_valid;
         end
         SER_SHIFT: begin
            if (out_ready) begin
               if (is_last) begin
                  in_ready = 1'b1;
                  load     = in_valid;
               end else begin
                  inc = 1'b1;
               end
            end
         end
         default: ;
      endcase

      shreg_d = shreg_q;
      if (load) begin
         shreg_d = WORD_W'(in_word);
      end else if (inc) begin
         shreg_d = shreg_q << NIB_W;
      end
   end

   assign shifting     = (state_q == SER_SHIFT);
   assign out_valid    = shifting;
   assign busy         = shifting;
   assign out_nib      = shifting ? shreg_q[WORD_W-1 -: NIB_W] : '0;
   assign out_last     = shifting & is_last;
   assign out_beat_idx = shifting ? cnt : '0;

`ifdef SER_PARITY_EN
   assign out_par = ^out_nib;
`endif

endmodule

// File: tb/tb_iem_nibble_serializer.sv
// Directed self-checking bench for iem_nibble_serializer (tests 1-5, plus 6 with SER_PARITY_EN).
module tb_iem_nibble_serializer;

   logic        clk;
   logic        rst_n;
   logic [47:0] in_word;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  out_nib;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [3:0]  out_beat_idx;
   logic        busy;
`ifdef SER_PARITY_EN
   logic        out_par;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] nib;
      logic [3:0] idx;
      logic       last;
   } beat_t;

   beat_t t1 [12];

   iem_nibble_serializer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_word      (in_word),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_nib      (out_nib),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .out_beat_idx (out_beat_idx),
      .busy         (busy)
`ifdef SER_PARITY_EN
      ,
      .out_par      (out_par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_word(input logic [47:0] w);
      in_word  = w;
      in_valid = 1'b1;
      #1 chk("load_in_ready", 48'(in_ready), 48'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic check_beat(input string nm, input logic [3:0] nib,
                             input logic [3:0] idx, input logic last);
      #1;
      chk({nm, "_valid"}, 48'(out_valid), 48'd1);
      chk({nm, "_nib"},   48'(out_nib),   48'(nib));
      chk({nm, "_idx"},   48'(out_beat_idx), 48'(idx));
      chk({nm, "_last"},  48'(out_last),  48'(last));
   endtask

   initial begin
      logic [47:0] w;
      int k;
      int c;

      for (int i = 0; i < 12; i++) begin
         t1[i].nib  = 4'(15 - i);
         t1[i].idx  = 4'(i);
         t1[i].last = (i == 11);
      end

      rst_n = 1'b0; in_word = '0; in_valid = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_valid", 48'(out_valid), 48'd0);
      chk("rst_nib",   48'(out_nib),   48'd0);
      chk("rst_last",  48'(out_last),  48'd0);
      chk("rst_idx",   48'(out_beat_idx), 48'd0);
      chk("rst_busy",  48'(busy),      48'd0);
      chk("rst_in_ready", 48'(in_ready), 48'd1);
`ifdef SER_PARITY_EN
      chk("rst_par",   48'(out_par),   48'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Test 1: free-running beats
      out_ready = 1'b1;
      load_word(48'hFEDC_BA98_7654);
      for (int i = 0; i < 12; i++) begin
         check_beat("t1", t1[i].nib, t1[i].idx, t1[i].last);
         chk("t1_busy", 48'(busy), 48'd1);
         step();
      end
      #1;
      chk("t1_idle_valid", 48'(out_valid), 48'd0);
      chk("t1_idle_in_ready", 48'(in_ready), 48'd1);
      @(negedge clk);

      // Test 2: backpressure pattern 1,0,0
      load_word(48'hFEDC_BA98_7654);
      k = 0; c = 0;
      while (k < 12 && c < 100) begin
         out_ready = (c % 3 == 0);
         check_beat("t2", t1[k].nib, t1[k].idx, t1[k].last);
         @(posedge clk);
         if (out_ready) k++;
         c++;
         @(negedge clk);
      end
      chk("t2_beats_done", 48'(k), 48'd12);
      out_ready = 1'b1;
      #1 chk("t2_idle_valid", 48'(out_valid), 48'd0);
      @(negedge clk);

      // Test 3: back-to-back words, no bubble
      in_word = 48'h1111_1111_1111; in_valid = 1'b1;
      #1 chk("t3_accept_a", 48'(in_ready), 48'd1);
      step();
      in_word = 48'h2222_2222_2222;
      for (int i = 0; i < 24; i++) begin
         if (i == 23) in_valid = 1'b0;
         check_beat("t3", (i < 12) ? 4'h1 : 4'h2, 4'(i % 12), (i % 12) == 11);
         if (i < 23) chk("t3_in_ready", 48'(in_ready), 48'(i == 11));
         step();
      end
      #1 chk("t3_idle_valid", 48'(out_valid), 48'd0);
      @(negedge clk);

      // Test 4: reset mid-word, then a fresh word starts at beat 0
      w = 48'hABCD_EF01_2345;
      load_word(w);
      for (int i = 0; i < 5; i++) step();
      check_beat("t4_pre", 4'hF, 4'd5, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_valid", 48'(out_valid), 48'd0);
      chk("t4_rst_busy",  48'(busy),      48'd0);
      chk("t4_rst_nib",   48'(out_nib),   48'd0);
      chk("t4_rst_idx",   48'(out_beat_idx), 48'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      load_word(48'h0000_0000_000F);
      for (int i = 0; i < 12; i++) begin
         check_beat("t4", (i == 11) ? 4'hF : 4'h0, 4'(i), i == 11);
         step();
      end
      #1 chk("t4_idle_valid", 48'(out_valid), 48'd0);
      @(negedge clk);

      // Test 5: word offered mid-stream waits for the last-beat handshake
      w = 48'h1234_5678_9ABC;
      load_word(w);
      for (int i = 0; i < 12; i++) begin
         if (i >= 3) begin
            in_word = 48'hCAFE_0000_BEEF; in_valid = 1'b1;
         end
         check_beat("t5_a", w[47 - 4*i -: 4], 4'(i), i == 11);
         chk("t5_in_ready", 48'(in_ready), 48'(i == 11));
         step();
      end
      in_valid = 1'b0;
      w = 48'hCAFE_0000_BEEF;
      for (int i = 0; i < 12; i++) begin
         check_beat("t5_b", w[47 - 4*i -: 4], 4'(i), i == 11);
         step();
      end
      #1 chk("t5_idle_valid", 48'(out_valid), 48'd0);
      @(negedge clk);

`ifdef SER_PARITY_EN
      // Test 6: even parity per beat
      load_word(48'h7300_0000_0000);
      #1;
      chk("t6_nib7", 48'(out_nib), 48'h7);
      chk("t6_par7", 48'(out_par), 48'd1);
      step();
      #1;
      chk("t6_nib3", 48'(out_nib), 48'h3);
      chk("t6_par3", 48'(out_par), 48'd0);
      for (int i = 1; i < 12; i++) step();
      #1 chk("t6_idle_par", 48'(out_par), 48'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule
